nfca_rx_hex_formatter: RTL and testbench

Converts the NFC-A receive stream produced by `nfca_controller` (data beats plus `no_card` pulses) into a flow-controlled stream of printable ASCII bytes for a single-byte UART transmitter. It buffers whole receive records in an internal FIFO so that bursts from the controller, which has no back-pressure, are never stalled. It then serialises each record into hex characters and status markers. It sits between `nfca_controller` and the UART TX path.

---
 rtl/nfca_rx_hex_formatter.sv | 182 ++++++++++++++++++
 tb/tb_nfca_rx_hex_formatter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nfca_rx_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module   : nfca_rx_hex_formatter
// Brief    : Buffers NFC-A receive records and serialises them as ASCII hex
//            characters with status markers for a byte-wide UART TX stream.
// Revision : 1.0 - initial release
// ============================================================================
module nfca_rx_hex_formatter #(
    parameter int FIFO_ASIZE = 6
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_tvalid,
    input  logic [7:0] rx_tdata,
    input  logic       rx_tlast,
    input  logic [3:0] rx_tlastb,
    input  logic       rx_tlast_err,
    input  logic       rx_tlast_col,
    input  logic       no_card,
    output logic       otvalid,
    input  logic       otready,
    output logic [7:0] otdata,
    output logic       overflow,
    output logic [15:0] drop_cnt
);

    localparam int          c_DEPTH = 1 << FIFO_ASIZE;
    localparam logic [7:0]  c_CH_E  = 8'h65;
    localparam logic [7:0]  c_CH_C  = 8'h63;
    localparam logic [7:0]  c_CH_CL = 8'h3A;
    localparam logic [7:0]  c_CH_N  = 8'h6E;
    localparam logic [7:0]  c_CH_LF = 8'h0A;
    localparam logic [7:0]  c_CH_SP = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HI     = 3'd1,
        S_LO     = 3'd2,
        S_MARK   = 3'd3,
        S_BITS   = 3'd4,
        S_END    = 3'd5,
        S_NC     = 3'd6,
        S_NC_END = 3'd7
    } state_t;

    // Record layout: [15] no-card, [14:7] tdata, [6] tlast, [5:2] tlastb,
    // [1] err, [0] col
    logic [15:0]           r_mem [c_DEPTH];
    logic [FIFO_ASIZE-1:0] r_wr_ptr;
    logic [FIFO_ASIZE-1:0] r_rd_ptr;
    logic [FIFO_ASIZE:0]   r_count;
    logic                  r_overflow;
    logic [15:0]           r_drop_cnt;

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_rec;
    logic [15:0]           w_rec_next;
    logic [7:0]            r_otdata;
    logic [7:0]            w_byte_next;

    logic [15:0]           w_rec_in;
    logic [15:0]           w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_req;
    logic                  w_wr_en;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_fire;
    logic                  w_need_mark;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        f_hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // A simultaneous data beat is silently superseded by the no-card record
    assign w_rec_in = no_card ? {1'b1, 15'h0000}
                              : {1'b0, rx_tdata, rx_tlast, rx_tlastb,
                                 rx_tlast_err, rx_tlast_col};
    assign w_head   = r_mem[r_rd_ptr];
    assign w_empty  = (r_count == '0);
    assign w_full   = r_count[FIFO_ASIZE];
    assign w_wr_req = rx_tvalid | no_card;
    assign w_wr_en  = w_wr_req & ~w_full;
    assign w_drop   = w_wr_req & w_full;
    assign w_pop    = (r_state == S_IDLE) & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_rec_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    assign w_fire      = (r_state != S_IDLE) & otready;
    assign w_need_mark = r_rec[1] | r_rec[0] | ~r_rec[5];

    always_comb begin
        w_state_next = r_state;
        w_rec_next   = r_rec;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_rec_next   = w_head;
                    w_state_next = w_head[15] ? S_NC : S_HI;
                end
            end
            S_HI:     if (w_fire) w_state_next = S_LO;
            S_LO:     if (w_fire) w_state_next = w_need_mark ? S_MARK : S_END;
            S_MARK:   if (w_fire) w_state_next = S_BITS;
            S_BITS:   if (w_fire) w_state_next = S_END;
            S_END:    if (w_fire) w_state_next = S_IDLE;
            S_NC:     if (w_fire) w_state_next = S_NC_END;
            S_NC_END: if (w_fire) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Byte for the state being entered; a stall keeps state and record, so
    // the registered byte holds its value.
    always_comb begin
        w_byte_next = 8'h00;
        case (w_state_next)
            S_HI:     w_byte_next = f_hex(w_rec_next[14:11]);
            S_LO:     w_byte_next = f_hex(w_rec_next[10:7]);
            S_MARK:   w_byte_next = w_rec_next[1] ? c_CH_E :
                                    (w_rec_next[0] ? c_CH_C : c_CH_CL);
            S_BITS:   w_byte_next = f_hex(w_rec_next[5:2]);
            S_END:    w_byte_next = w_rec_next[6] ? c_CH_LF : c_CH_SP;
            S_NC:     w_byte_next = c_CH_N;
            S_NC_END: w_byte_next = c_CH_LF;
            default:  w_byte_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_rec    <= 16'h0000;
            r_otdata <= 8'h00;
        end else begin
            r_state  <= w_state_next;
            r_rec    <= w_rec_next;
            r_otdata <= w_byte_next;
        end
    end

    assign otvalid  = (r_state != S_IDLE);
    assign otdata   = r_otdata;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nfca_rx_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nfca_rx_hex_formatter
// Brief    : Directed self-checking bench for nfca_rx_hex_formatter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nfca_rx_hex_formatter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_tvalid = 1'b0;
    logic [7:0]  rx_tdata = 8'h00;
    logic        rx_tlast = 1'b0;
    logic [3:0]  rx_tlastb = 4'h8;
    logic        rx_tlast_err = 1'b0;
    logic        rx_tlast_col = 1'b0;
    logic        no_card = 1'b0;
    logic        otvalid;
    logic        otready = 1'b0;
    logic [7:0]  otdata;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    nfca_rx_hex_formatter #(.FIFO_ASIZE(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_tvalid    (rx_tvalid),
        .rx_tdata     (rx_tdata),
        .rx_tlast     (rx_tlast),
        .rx_tlastb    (rx_tlastb),
        .rx_tlast_err (rx_tlast_err),
        .rx_tlast_col (rx_tlast_col),
        .no_card      (no_card),
        .otvalid      (otvalid),
        .otready      (otready),
        .otdata       (otdata),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic [3:0] lastb,
                             input logic err, input logic col);
        rx_tvalid = 1'b1; rx_tdata = d; rx_tlast = last; rx_tlastb = lastb;
        rx_tlast_err = err; rx_tlast_col = col;
        tick();
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tlast_err = 1'b0; rx_tlast_col = 1'b0;
    endtask

    // {otvalid, otdata} must show exp, held through 'stall' refused cycles
    task automatic expect_byte(input string tag, input logic [7:0] exp, input int stall);
        int k = 0;
        while (!otvalid && k < 32) begin
            tick();
            k++;
        end
        for (int s = 0; s < stall; s++) begin
            otready = 1'b0;
            tick();
            check({tag, "_stall"}, {7'd0, otvalid, otdata}, {8'h01, exp});
        end
        otready = 1'b1;
        check(tag, {7'd0, otvalid, otdata}, {8'h01, exp});
        tick();
    endtask

    task automatic expect_rec(input string tag, input logic [39:0] bytes, input int n,
                              input int stall);
        for (int i = 0; i < n; i++) begin
            expect_byte(tag, bytes[8*(n-1-i) +: 8], stall);
        end
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        otready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            check(tag, {15'd0, otvalid}, 16'h0000);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // Reset state
        rstn = 1'b0;
        tick(); tick();
        check("rst_otvalid", {15'd0, otvalid}, 16'h0000);
        check("rst_otdata", {8'd0, otdata}, 16'h0000);
        check("rst_overflow", {15'd0, overflow}, 16'h0000);
        check("rst_drop_cnt", drop_cnt, 16'h0000);
        rstn = 1'b1;
        tick();

        // Single beat 0x3A and its two-cycle latency
        otready = 1'b1;
        send_beat(8'h3A, 1'b0, 4'h8, 1'b0, 1'b0);
        check("lat_edge_n", {15'd0, otvalid}, 16'h0000);
        tick();
        check("lat_edge_n1", {7'd0, otvalid, otdata}, 16'h0133);
        expect_rec("beat_3A", {8'h33, 8'h41, 8'h20}, 3, 0);
        expect_idle("beat_3A_idle", 2);

        // Partial last byte
        send_beat(8'h04, 1'b1, 4'h4, 1'b0, 1'b0);
        expect_rec("partial_04", {8'h30, 8'h34, 8'h3A, 8'h34, 8'h0A}, 5, 0);

        // Error beats collision; then collision alone
        send_beat(8'hFF, 1'b1, 4'h3, 1'b1, 1'b1);
        expect_rec("err_col", {8'h46, 8'h46, 8'h65, 8'h33, 8'h0A}, 5, 1);
        send_beat(8'hFF, 1'b1, 4'h3, 1'b0, 1'b1);
        expect_rec("col_only", {8'h46, 8'h46, 8'h63, 8'h33, 8'h0A}, 5, 0);
        expect_idle("col_idle", 2);

        // No-card wins over a simultaneous data beat
        rx_tvalid = 1'b1; rx_tdata = 8'h12; no_card = 1'b1;
        tick();
        rx_tvalid = 1'b0; no_card = 1'b0;
        expect_rec("nc_prio", {8'h6E, 8'h0A}, 2, 0);
        expect_idle("nc_prio_idle", 5);
        check("nc_prio_drop", drop_cnt, 16'h0000);
        no_card = 1'b1;
        tick();
        no_card = 1'b0;
        expect_rec("nc_alone", {8'h6E, 8'h0A}, 2, 0);
        expect_idle("nc_alone_idle", 2);

        // Overflow: FSM parked on a no-card record, then 6 beats into 4 slots
        otready = 1'b0;
        no_card = 1'b1;
        tick();
        no_card = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            send_beat(8'(i), 1'b0, 4'h8, 1'b0, 1'b0);
        end
        check("ovf_flag", {15'd0, overflow}, 16'h0001);
        check("ovf_drop_cnt", drop_cnt, 16'h0002);
        expect_rec("ovf_nc", {8'h6E, 8'h0A}, 2, 2);
        for (int i = 0; i < 4; i++) begin
            expect_rec("ovf_rec", {8'h30, 8'h30 + 8'(i), 8'h20}, 3, 2);
        end
        expect_idle("ovf_idle", 6);
        check("ovf_drop_hold", drop_cnt, 16'h0002);

        // Reset while the low nibble is presented under random stalls
        otready = 1'b0;
        send_beat(8'hA5, 1'b1, 4'h8, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (otvalid && otdata == 8'h35) begin
                found = 1'b1;
            end else begin
                otready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        check("mid_reach_lo", {15'd0, found}, 16'h0001);
        otready = 1'b0;
        rstn = 1'b0;
        tick();
        check("mid_rst_otvalid", {15'd0, otvalid}, 16'h0000);
        check("mid_rst_overflow", {15'd0, overflow}, 16'h0000);
        check("mid_rst_drop_cnt", drop_cnt, 16'h0000);
        rstn = 1'b1;
        tick();
        expect_idle("mid_rst_idle", 3);
        send_beat(8'h7C, 1'b1, 4'h8, 1'b0, 1'b0);
        expect_rec("post_rst", {8'h37, 8'h43, 8'h0A}, 3, 1);
        expect_idle("post_rst_idle", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
